// File: rtl/ifu_prefetch_pkg.sv
// Shared fetch-unit definitions: default widths, reset vector,
// and the instruction-queue entry layout.
package ifu_defines;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bundle: redirect, consumer side and memory side.
// master is the prefetcher, slave is its environment.
interface ifu_prefetch_if
  import ifu_defines::*;
#(
  parameter int XLEN = XLEN_DEF
) ();

  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            pop;
  logic            inst_valid;
  logic [XLEN-1:0] inst_rdata;
  logic [XLEN-1:0] inst_pc;
  logic            mem_reqValid;
  logic [XLEN-1:0] mem_addr;
  logic            mem_respValid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  flush, flush_pc, pop,
    input  mem_respValid, mem_rdata,
    output inst_valid, inst_rdata, inst_pc,
    output mem_reqValid, mem_addr
  );

  modport slave (
    output flush, flush_pc, pop,
    output mem_respValid, mem_rdata,
    input  inst_valid, inst_rdata, inst_pc,
    input  mem_reqValid, mem_addr
  );

endinterface

// File: rtl/ifu_prefetch_sync_fifo.sv
// Register-based synchronous FIFO with count/full/empty.
// Any depth >= 1; pointers wrap explicitly at DEPTH-1.
module sync_fifo
  import ifu_defines::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: credit-limited sequential fetch into a
// small queue, with flush that discards in-flight responses.
module ifu_prefetch
  import ifu_defines::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            pop,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_rdata,
  output logic [XLEN-1:0] inst_pc,
  output logic            mem_reqValid,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_respValid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int QW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   live_q, live_d;
  logic [OW-1:0]   discard_q, discard_d;

  logic          issue;
  logic          resp_ok, resp_keep, resp_drop;
  logic          iq_push, iq_pop;
  entry_t        iq_wdata, iq_head;
  logic [QW-1:0] iq_count;
  logic          iq_full, iq_empty;
  logic [XLEN-1:0] aq_head;
  logic [OW-1:0] aq_count;
  logic          aq_full, aq_empty;
  logic          unused_ok;

  // Credits: memory-side slots and queue room reserved by live fetches
  assign issue = !reset
    && ((32'(live_q) + 32'(discard_q)) < MAX_OUT)
    && ((32'(iq_count) + 32'(live_q)) < DEPTH);

  assign mem_reqValid = issue;
  assign mem_addr     = fetch_pc_q;

  assign resp_ok   = mem_respValid
    && ((live_q != '0) || (discard_q != '0));
  assign resp_drop = resp_ok && (discard_q != '0);
  assign resp_keep = resp_ok && (discard_q == '0);

  assign iq_push  = resp_keep && !flush;
  assign iq_pop   = pop && !iq_empty && !flush;
  assign iq_wdata = '{pc: aq_head, inst: mem_rdata};

  assign inst_valid = !iq_empty;
  assign inst_rdata = iq_head.inst;
  assign inst_pc    = iq_head.pc;

  assign unused_ok = ^{iq_full, aq_count, aq_full, aq_empty};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    live_d     = live_q;
    discard_d  = discard_q;
    if (flush) begin
      // Older requests, including one leaving now, become discards
      fetch_pc_d = flush_pc;
      live_d     = '0;
      discard_d  = discard_q + live_q
                 + OW'(issue) - OW'(resp_ok);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      end
      live_d    = live_q + OW'(issue) - OW'(resp_keep);
      discard_d = discard_q - OW'(resp_drop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      live_q     <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_iq (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (iq_push),
    .wdata (iq_wdata),
    .pop   (iq_pop),
    .rdata (iq_head),
    .count (iq_count),
    .full  (iq_full),
    .empty (iq_empty)
  );

  // Address of each outstanding request, popped as responses return
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_aq (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .push  (issue),
    .wdata (fetch_pc_q),
    .pop   (resp_ok),
    .rdata (aq_head),
    .count (aq_count),
    .full  (aq_full),
    .empty (aq_empty)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: memory responder with
// configurable latency or hand-driven responses.
module tb_ifu_prefetch;
  import ifu_defines::*;

  logic clock;
  logic reset;

  ifu_prefetch_if #(.XLEN(32)) bus ();

  int checks = 0;
  int failures = 0;

  int lat = 1;
  bit manual = 1'b0;
  logic man_valid = 1'b0;
  logic [31:0] man_data = '0;
  logic auto_valid = 1'b0;
  logic [31:0] auto_data = '0;
  int cyc = 0;
  int max_seen = 0;
  logic [31:0] q_addr [$];
  int q_due [$];

  assign bus.mem_respValid = manual ? man_valid : auto_valid;
  assign bus.mem_rdata     = manual ? man_data : auto_data;

  ifu_prefetch #(
    .XLEN     (32),
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (bus.flush),
    .flush_pc      (bus.flush_pc),
    .pop           (bus.pop),
    .inst_valid    (bus.inst_valid),
    .inst_rdata    (bus.inst_rdata),
    .inst_pc       (bus.inst_pc),
    .mem_reqValid  (bus.mem_reqValid),
    .mem_addr      (bus.mem_addr),
    .mem_respValid (bus.mem_respValid),
    .mem_rdata     (bus.mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // In-order memory: data = ~address, valid lat cycles after accept
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      auto_valid <= 1'b0;
      max_seen <= 0;
    end else begin
      auto_valid <= 1'b0;
      if (bus.mem_reqValid) begin
        q_addr.push_back(bus.mem_addr);
        q_due.push_back(cyc + lat - 1);
      end
      if (q_addr.size() > max_seen) max_seen <= q_addr.size();
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        auto_valid <= 1'b1;
        auto_data <= ~q_addr[0];
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag,
                          input logic [31:0] pc);
    iq_entry_t e;
    e.pc = pc;
    e.inst = ~pc;
    chk({tag, "_pc"}, bus.inst_pc, e.pc);
    chk({tag, "_data"}, bus.inst_rdata, e.inst);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.inst_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.pop = 1'b0;
    man_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req_low", 32'(bus.mem_reqValid), 32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    bit ok;
    int n;
    logic [31:0] exp_pc;

    // Reset release, latency 1, no pop: queue fills to 4
    do_reset();
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_inst_rdata", bus.inst_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("fill_req", 32'(bus.mem_reqValid), 32'd1);
      chk("fill_addr", bus.mem_addr, 32'h8000_0000 + 32'(4 * i));
      @(negedge clock);
    end
    chk("fill_stop", 32'(bus.mem_reqValid), 32'd0);
    repeat (2) @(negedge clock);
    chk("fill_stop2", 32'(bus.mem_reqValid), 32'd0);
    chk("fill_count", 32'(dut.iq_count), 32'd4);
    chk("fill_valid", 32'(bus.inst_valid), 32'd1);
    chk_head("fill_head", 32'h8000_0000);

    // Latency 3 with continuous pop: gapless +4 stream
    lat = 3;
    bus.pop = 1'b1;
    exp_pc = 32'h8000_0000;
    n = 0;
    for (int k = 0; k < 100 && n < 12; k++) begin
      if (bus.inst_valid) begin
        chk_head("stream", exp_pc);
        exp_pc += 32'd4;
        n++;
      end
      @(negedge clock);
    end
    bus.pop = 1'b0;
    chk("stream_count", n, 12);
    chk("stream_max_out", max_seen, 2);

    // Flush with two requests in flight
    manual = 1'b0;
    lat = 3;
    do_reset();
    @(negedge clock);
    chk("f1_req", 32'(bus.mem_reqValid), 32'd1);
    chk("f1_addr", bus.mem_addr, 32'h8000_0004);
    @(negedge clock);
    chk("f1_full", 32'(bus.mem_reqValid), 32'd0);
    bus.flush = 1'b1;
    bus.flush_pc = 32'h100;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("f1_req_held", 32'(bus.mem_reqValid), 32'd0);
    chk("f1_discard2", 32'(dut.discard_q), 32'd2);
    chk("f1_empty", 32'(bus.inst_valid), 32'd0);
    @(negedge clock);
    chk("f1_discard1", 32'(dut.discard_q), 32'd1);
    chk("f1_new_req", 32'(bus.mem_reqValid), 32'd1);
    chk("f1_new_addr", bus.mem_addr, 32'h100);
    wait_valid(30, ok);
    chk("f1_seen", 32'(ok), 32'd1);
    chk_head("f1_first", 32'h100);

    // Spurious response ignored; flush with resp and pop together
    manual = 1'b1;
    do_reset();
    man_valid = 1'b1;
    man_data = 32'hBAD0_BAD0;
    @(negedge clock);
    man_data = ~32'h8000_0000;
    @(negedge clock);
    chk("sp_valid", 32'(bus.inst_valid), 32'd1);
    chk("sp_count", 32'(dut.iq_count), 32'd1);
    chk_head("sp_head", 32'h8000_0000);
    chk("sp_req", 32'(bus.mem_reqValid), 32'd1);
    chk("sp_addr", bus.mem_addr, 32'h8000_0008);
    man_data = 32'h1111_2222;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h400;
    bus.pop = 1'b1;
    @(negedge clock);
    man_valid = 1'b0;
    bus.flush = 1'b0;
    bus.pop = 1'b0;
    chk("fr_empty", 32'(bus.inst_valid), 32'd0);
    chk("fr_count", 32'(dut.iq_count), 32'd0);
    chk("fr_discard", 32'(dut.discard_q), 32'd1);
    chk("fr_live", 32'(dut.live_q), 32'd0);
    chk("fr_req", 32'(bus.mem_reqValid), 32'd1);
    chk("fr_addr", bus.mem_addr, 32'h400);
    @(negedge clock);
    chk("fr_credit", 32'(bus.mem_reqValid), 32'd0);
    man_valid = 1'b1;
    man_data = 32'h3333_4444;
    @(negedge clock);
    chk("fr_drop_disc", 32'(dut.discard_q), 32'd0);
    chk("fr_drop_empty", 32'(bus.inst_valid), 32'd0);
    chk("fr_req2", 32'(bus.mem_reqValid), 32'd1);
    chk("fr_addr2", bus.mem_addr, 32'h404);
    man_data = ~32'h400;
    @(negedge clock);
    man_valid = 1'b0;
    chk("fr_valid", 32'(bus.inst_valid), 32'd1);
    chk_head("fr_head", 32'h400);

    // Back-to-back flushes while discards pending
    manual = 1'b0;
    lat = 3;
    do_reset();
    @(negedge clock);
    @(negedge clock);
    bus.flush = 1'b1;
    bus.flush_pc = 32'h200;
    @(negedge clock);
    bus.flush_pc = 32'h300;
    chk("bb_req", 32'(bus.mem_reqValid), 32'd0);
    chk("bb_disc2", 32'(dut.discard_q), 32'd2);
    @(negedge clock);
    bus.flush = 1'b0;
    chk("bb_disc1", 32'(dut.discard_q), 32'd1);
    chk("bb_new_req", 32'(bus.mem_reqValid), 32'd1);
    chk("bb_new_addr", bus.mem_addr, 32'h300);
    wait_valid(30, ok);
    chk("bb_seen", 32'(ok), 32'd1);
    chk_head("bb_first", 32'h300);

    // Address wrap and pop on empty
    manual = 1'b1;
    do_reset();
    bus.flush = 1'b1;
    bus.flush_pc = 32'hFFFF_FFFC;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("wr_req", 32'(bus.mem_reqValid), 32'd1);
    chk("wr_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("wr_disc", 32'(dut.discard_q), 32'd1);
    @(negedge clock);
    chk("wr_wrap", bus.mem_addr, 32'h0000_0000);
    chk("wr_credit", 32'(bus.mem_reqValid), 32'd0);
    chk("wr_live", 32'(dut.live_q), 32'd1);
    bus.pop = 1'b1;
    @(negedge clock);
    bus.pop = 1'b0;
    chk("pe_count", 32'(dut.iq_count), 32'd0);
    chk("pe_valid", 32'(bus.inst_valid), 32'd0);
    chk("pe_addr", bus.mem_addr, 32'h0000_0000);
    chk("pe_live", 32'(dut.live_q), 32'd1);
    chk("pe_disc", 32'(dut.discard_q), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
